// File: rtl/order_manager.sv
// Order issue stage: turns buy/sell decisions into valid/ready orders under a signed position limit.
// Optional post-order cooldown is built only when COOLDOWN_EN is defined.
module order_manager #(
    parameter int POS_W           = 8,
    parameter int MAX_POS         = 8,
    parameter int ORDER_QTY       = 1,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             buy_signal,
    input  logic             sell_signal,
    input  logic [7:0]       price_in,
    output logic             order_valid,
    input  logic             order_ready,
    output logic             order_side,
    output logic [7:0]       order_price,
    output logic [7:0]       order_qty,
    output logic [POS_W-1:0] position,
    output logic [15:0]      drop_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE
`ifdef COOLDOWN_EN
        , COOLDOWN
`endif
    } state_t;

    localparam logic [7:0]             QTY8  = 8'(ORDER_QTY);
    localparam logic [POS_W-1:0]       QTY_P = POS_W'(ORDER_QTY);
    localparam logic signed [POS_W:0]  QTY_S = (POS_W+1)'(ORDER_QTY);
    localparam logic signed [POS_W:0]  MAX_S = (POS_W+1)'(MAX_POS);

    if (MAX_POS >= 2**(POS_W-1) || ORDER_QTY < 1 || ORDER_QTY > MAX_POS || COOLDOWN_CYCLES < 1)
    begin : g_param_check
        $error("order_manager: illegal parameter combination");
    end

    state_t state, state_nx;
    logic   latch, drop, hs;
    logic   buy_ok, sell_ok;
    logic signed [POS_W:0] pos_ext, pos_up, pos_dn;

`ifdef COOLDOWN_EN
    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    logic [CNT_W-1:0] cd_cnt;
`endif

    // Limit checks run one bit wider than the position so they cannot wrap.
    always_comb begin
        pos_ext = {position[POS_W-1], position};
        pos_up  = pos_ext + QTY_S;
        pos_dn  = pos_ext - QTY_S;
        buy_ok  = (pos_up <= MAX_S);
        sell_ok = (pos_dn >= -MAX_S);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        drop     = 1'b0;
        hs       = (state == ISSUE) && order_ready;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (buy_signal && sell_signal) begin
                        drop = 1'b1;
                    end else if (buy_signal) begin
                        if (buy_ok) begin
                            latch    = 1'b1;
                            state_nx = ISSUE;
                        end else begin
                            drop = 1'b1;
                        end
                    end else if (sell_signal) begin
                        if (sell_ok) begin
                            latch    = 1'b1;
                            state_nx = ISSUE;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                drop = enable && (buy_signal || sell_signal);
                if (order_ready) begin
`ifdef COOLDOWN_EN
                    state_nx = COOLDOWN;
`else
                    state_nx = IDLE;
`endif
                end
            end
`ifdef COOLDOWN_EN
            COOLDOWN: begin
                drop = enable && (buy_signal || sell_signal);
                if (cd_cnt == '0) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            order_side  <= 1'b0;
            order_price <= '0;
            order_qty   <= '0;
            position    <= '0;
            drop_count  <= '0;
        end else begin
            if (latch) begin
                order_side  <= buy_signal;
                order_price <= price_in;
                order_qty   <= QTY8;
            end
            if (hs) position <= order_side ? position + QTY_P : position - QTY_P;
            if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
        end
    end

`ifdef COOLDOWN_EN
    always_ff @(posedge clk) begin
        if (rst)                                  cd_cnt <= '0;
        else if (hs)                              cd_cnt <= CD_LOAD;
        else if (state == COOLDOWN && cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;
    end
`endif

    assign order_valid = (state == ISSUE);
    assign busy        = (state != IDLE);

endmodule
